// File: rtl/insn_encoder_loader.sv
// insn_encoder_loader
//    Encodes symbolic LEGv8 instruction requests (kind + register/immediate
//    fields) into 32-bit words and writes them one after another into the
//    instruction-memory write port, starting at word 0.
//
// Ports
//    clk         system clock, rising edge
//    reset       asynchronous active-low reset
//    start       pulse: clear address/count/err, enter RUN
//    req_valid   request present
//    req_ready   request can be accepted this cycle
//    req_kind    0=LDUR 1=STUR 2=CBZ 3=ADD 4=SUB 5=AND 6=ORR 7=illegal
//    req_rd      Rd (R-type) / Rt (D-type, CB-type)
//    req_rn      Rn
//    req_rm      Rm (R-type only)
//    req_imm     D-type uses [8:0], CB-type uses [18:0]
//    imem_we     write strobe, one cycle per encoded word
//    imem_waddr  word address of the write
//    imem_wdata  encoded instruction
//    word_count  words written since last start (saturates at DEPTH)
//    full        DEPTH words written
//    err         sticky; an illegal kind was accepted since last start
//
// state  | meaning
// S_IDLE | after reset, waiting for start
// S_RUN  | accepting requests, one write per legal request
// S_FULL | all DEPTH slots written, no further requests until start

module insn_encoder_loader #(
   parameter int DEPTH = 64,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          start,
   input  logic          req_valid,
   output logic          req_ready,
   input  logic [2:0]    req_kind,
   input  logic [4:0]    req_rd,
   input  logic [4:0]    req_rn,
   input  logic [4:0]    req_rm,
   input  logic [18:0]   req_imm,
   output logic          imem_we,
   output logic [AW-1:0] imem_waddr,
   output logic [31:0]   imem_wdata,
   output logic [AW:0]   word_count,
   output logic          full,
   output logic          err
);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_FULL} state_t;

   localparam logic [AW:0] LAST_SLOT = (AW+1)'(DEPTH - 1);

   state_t      state, state_nxt;
   logic        accept;
   logic        legal;
   logic [31:0] enc_word;

   assign legal  = (req_kind != 3'd7);
   assign accept = req_valid & req_ready;
   assign full   = (state == S_FULL);

   always_comb begin
      enc_word = 32'h0;
      case (req_kind)
         3'd0:    enc_word = {11'b11111000010, req_imm[8:0], 2'b00, req_rn, req_rd};
         3'd1:    enc_word = {11'b11111000000, req_imm[8:0], 2'b00, req_rn, req_rd};
         3'd2:    enc_word = {8'b10110100, req_imm, req_rd};
         3'd3:    enc_word = {11'b10001011000, req_rm, 6'b000000, req_rn, req_rd};
         3'd4:    enc_word = {11'b11001011000, req_rm, 6'b000000, req_rn, req_rd};
         3'd5:    enc_word = {11'b10001010000, req_rm, 6'b000000, req_rn, req_rd};
         3'd6:    enc_word = {11'b10101010000, req_rm, 6'b000000, req_rn, req_rd};
         default: enc_word = 32'h0;
      endcase
   end

   always_comb begin
      state_nxt = state;
      req_ready = (state == S_RUN) & ~start;
      if (start) begin
         state_nxt = S_RUN;
      end else begin
         case (state)
            S_RUN: begin
               // Only a real write consumes a slot; an illegal request at the
               // last slot leaves the slot free.
               if (accept && legal && (word_count == LAST_SLOT))
                  state_nxt = S_FULL;
            end
            default: state_nxt = state;
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state      <= S_IDLE;
         imem_we    <= 1'b0;
         imem_waddr <= '0;
         imem_wdata <= 32'h0;
         word_count <= '0;
         err        <= 1'b0;
      end else begin
         state   <= state_nxt;
         imem_we <= 1'b0;
         if (start) begin
            word_count <= '0;
            err        <= 1'b0;
         end else if (accept) begin
            if (legal) begin
               imem_we    <= 1'b1;
               // Address never wraps: FULL blocks acceptance once count hits DEPTH.
               imem_waddr <= word_count[AW-1:0];
               imem_wdata <= enc_word;
               word_count <= word_count + 1'b1;
            end else begin
               err <= 1'b1;
            end
         end
      end
   end

endmodule
